muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide engine that executes MULT, MULTU, DIV and DIVU and writes the 64-bit result into the HI/LO register pair. It sits between the execute stage and the HI/LO registers, driving their data inputs and per-register write strobes. Each operation is a radix-2 shift-add multiply or a restoring divide over 32 iterations. A busy/done handshake lets the pipeline stall until the result is committed.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-bit multiply/divide engine feeding the HI/LO pair.
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring) over 32
// iterations on unsigned magnitudes. A final FIX cycle applies sign
// correction. Every operation takes a fixed 34 cycles from the accepting edge
// to the DONE cycle.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        request, sampled only while idle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU (latched with start)
//   a, b         multiplicand/dividend, multiplier/divisor (latched with start)
//   busy         high from the cycle after an accepted start through DONE
//   done         one-cycle pulse in DONE
//   hi_out       HI result (product[63:32] or remainder)
//   lo_out       LO result (product[31:0] or quotient)
//   hi_we, lo_we write strobes, equal to done
//   div_by_zero  pulses with done when a divide had b == 0
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        hi_we,
   output logic        lo_we,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_q;     // product / quotient must be negated
   logic        neg_r;     // remainder must be negated (follows sign of a)
   logic        b_zero;
   logic        dbz_q;
   logic [31:0] a_q;       // original dividend, returned as HI on divide by zero
   logic [31:0] mcand;     // multiplicand magnitude, or divisor magnitude
   logic [63:0] acc;       // multiply: product/multiplier; divide: low half is dividend/quotient
   logic [31:0] rem;       // partial remainder; always < divisor so 32 bits suffice

   // Operand magnitudes at acceptance
   logic        sgn_op;
   logic [31:0] abs_a, abs_b;
   assign sgn_op = ~op[0];
   assign abs_a  = (sgn_op && a[31]) ? -a : a;
   assign abs_b  = (sgn_op && b[31]) ? -b : b;

   // One multiply step: add multiplicand into upper half, shift the 33-bit sum in
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
   assign mul_nxt = {mul_sum, acc[31:1]};

   // One restoring divide step on a 33-bit shifted remainder
   logic [32:0] div_shift;
   logic        div_ge;
   logic [32:0] div_diff;
   assign div_shift = {rem, acc[31]};
   assign div_ge    = div_shift >= {1'b0, mcand};
   assign div_diff  = div_shift - {1'b0, mcand};

   // Sign-corrected results for FIX
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;
   assign prod_fix = neg_q ? -acc : acc;
   assign quo_fix  = neg_q ? -acc[31:0] : acc[31:0];
   assign rem_fix  = neg_r ? -rem : rem;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (cnt == 5'd31) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the state register, stable for the whole cycle
   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      hi_we       = done;
      lo_we       = done;
      div_by_zero = done & dbz_q;
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         dbz_q  <= 1'b0;
         a_q    <= '0;
         mcand  <= '0;
         acc    <= '0;
         rem    <= '0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt    <= '0;
               is_div <= op[1];
               neg_q  <= sgn_op & (a[31] ^ b[31]);
               neg_r  <= sgn_op & a[31];
               b_zero <= (b == 32'd0);
               a_q    <= a;
               acc    <= {32'd0, op[1] ? abs_a : abs_b};
               mcand  <= op[1] ? abs_b : abs_a;
               rem    <= '0;
            end
            RUN: begin
               cnt <= cnt + 5'd1;
               if (is_div) begin
                  rem       <= div_ge ? div_diff[31:0] : div_shift[31:0];
                  acc[31:0] <= {acc[30:0], div_ge};
               end else begin
                  acc <= mul_nxt;
               end
            end
            FIX: begin
               if (!is_div) begin
                  hi_out <= prod_fix[63:32];
                  lo_out <= prod_fix[31:0];
                  dbz_q  <= 1'b0;
               end else if (b_zero) begin
                  hi_out <= a_q;
                  lo_out <= 32'hFFFF_FFFF;
                  dbz_q  <= 1'b1;
               end else begin
                  // 0x80000000 / -1 falls out naturally: magnitude quotient
                  // 0x80000000, no negation, remainder 0.
                  hi_out <= rem_fix;
                  lo_out <= quo_fix;
                  dbz_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, hi_we, lo_we, div_by_zero;
   logic [31:0] hi_out, lo_out;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
      .hi_we(hi_we), .lo_we(lo_we), .div_by_zero(div_by_zero)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [31:0] hi, lo;
      logic        dbz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the architectural definition
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      longint sx, sy, p, q, r;
      logic [63:0] up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      dbz = 1'b0;
      case (o)
         2'b00: begin p = sx * sy; hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin up = {32'd0, x} * {32'd0, y}; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (y == 0) begin
               hi = x; lo = 32'hFFFF_FFFF; dbz = 1'b1;
            end else if (o == 2'b10) begin
               q = sx / sy; r = sx % sy; hi = r[31:0]; lo = q[31:0];
            end else begin
               hi = x % y; lo = x / y;
            end
         end
      endcase
   endfunction

   // Issue one op at a negedge, observe cycles 1..36. Optionally pulse start
   // with junk operands in cycles 5 and 34.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit inj,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int done_cyc, output int ndone, output int busy_err, output int we_err);
      hi = '0; lo = '0; dbz = 1'b0; done_cyc = 0; ndone = 0; busy_err = 0; we_err = 0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      for (int n = 1; n <= 36; n++) begin
         @(negedge clk);
         if (busy !== (n <= 34)) busy_err++;
         if (hi_we !== done || lo_we !== done) we_err++;
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc == 0) begin
               done_cyc = n; hi = hi_out; lo = lo_out; dbz = div_by_zero;
            end
         end
         start = inj && (n == 4 || n == 33);  // held during cycles 5 and 34
         a = $urandom; b = $urandom; op = 2'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] hi, lo, ehi, elo;
      logic dbz, edbz;
      int dc, nd, be, we;
      model(o, x, y, ehi, elo, edbz);
      do_op(o, x, y, 1'b0, hi, lo, dbz, dc, nd, be, we);
      chk({name, ".result"}, {hi, lo}, {ehi, elo});
      chk({name, ".dbz"}, 64'(dbz), 64'(edbz));
      chk({name, ".latency"}, 64'(dc), 64'd34);
      if (nd != 1 || be != 0 || we != 0) chk({name, ".handshake"}, {32'(nd), 16'(be), 16'(we)}, {32'd1, 32'd0});
   endtask

   vec_t tbl[8];

   initial begin
      logic [31:0] hi, lo, x, y;
      logic dbz;
      int dc, nd, be, we, seen;
      logic [1:0] o;

      tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      tbl[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      tbl[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      tbl[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      tbl[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      tbl[6] = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
      tbl[7] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset.ctl", {59'd0, busy, done, hi_we, lo_we, div_by_zero}, 64'd0);
      chk("reset.data", {hi_out, lo_out}, 64'd0);
      rst = 1'b0;

      // Directed table
      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, hi, lo, dbz, dc, nd, be, we);
         chk($sformatf("tbl%0d.result", i), {hi, lo}, {tbl[i].hi, tbl[i].lo});
         chk($sformatf("tbl%0d.dbz", i), 64'(dbz), 64'(tbl[i].dbz));
         chk($sformatf("tbl%0d.latency", i), 64'(dc), 64'd34);
         chk($sformatf("tbl%0d.pulses", i), 64'(nd), 64'd1);
         chk($sformatf("tbl%0d.busy", i), 64'(be), 64'd0);
         chk($sformatf("tbl%0d.we", i), 64'(we), 64'd0);
      end

      // start pulses during RUN and DONE are ignored
      do_op(2'b01, 32'd3, 32'd4, 1'b1, hi, lo, dbz, dc, nd, be, we);
      chk("ignore.result", {hi, lo}, 64'd12);
      chk("ignore.latency", 64'(dc), 64'd34);
      chk("ignore.pulses", 64'(nd), 64'd1);
      chk("ignore.busy", 64'(be), 64'd0);

      // Reset mid-RUN: rst high during cycle 10 of a DIVU, and beforehand
      // clear hi/lo with a fresh reset so the post-abort zero check is meaningful
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
      start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;                       // held during cycle 10
      @(negedge clk);
      rst = 1'b0;
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.data", {hi_out, lo_out}, 64'd0);
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done || hi_we || lo_we || busy) seen++;
      end
      chk("abort.no_strobe", 64'(seen), 64'd0);
      run_check("after_abort", 2'b11, 32'd1000, 32'd3);

      // Randomized ops against the reference model
      for (int i = 0; i < 48; i++) begin
         o = 2'($urandom);
         x = $urandom;
         y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
         run_check($sformatf("rnd%0d_op%0d", i, o), o, x, y);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
